// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and small helpers used by every
// block that paces or decodes the raster.
package vga_pkg;

  // Horizontal timing, in pixels.
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines.
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // System clocks per pixel (100 MHz board clock -> 25 MHz pixel rate).
  localparam int VGA_CLK_DIV   = 4;

  // Sync levels while inside the sync window (both negative for this mode).
  localparam logic VGA_HS_POL  = 1'b0;
  localparam logic VGA_VS_POL  = 1'b0;

  // Raster counter width.
  localparam int VGA_CNT_W     = 11;

  // True when lo <= val < hi, all compares 11-bit unsigned.
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] val,
                                     input logic [VGA_CNT_W-1:0] lo,
                                     input logic [VGA_CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate clock enable: one-clk pix_en pulse every CLK_DIV system clocks.
// The pulse is the registered terminal count of the divider, so the first
// pulse arrives CLK_DIV clocks after reset release and CLK_DIV=1 yields a
// constant-high enable outside reset.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_en
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_en;
  logic             w_div_last;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign pix_en     = r_pix_en;

  // Divider counter wraps at CLK_DIV-1; pix_en registers the wrap cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      r_pix_en  <= w_div_last;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Counters advance on pix_en; every output is
// registered from the next-state counters so blank/hsync/vsync change on the
// same clk edge as the hcount/vcount they describe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = VGA_CLK_DIV,
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic HS_POL    = VGA_HS_POL,
  parameter logic VS_POL    = VGA_VS_POL
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  // Elaboration-time constants, all 11-bit unsigned.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic        w_pix_en;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_hcount_nxt;
  logic [10:0] w_vcount_nxt;

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_blank;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_en  (w_pix_en)
  );

  // Wraps only fire on a real pixel advance, never on the reset-exit state.
  assign w_h_wrap = w_pix_en && (r_hcount == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_vcount == V_LAST);

  // Next-state raster position.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_pix_en) begin
      if (r_hcount == H_LAST) begin
        w_hcount_nxt = '0;
        w_vcount_nxt = (r_vcount == V_LAST) ? 11'd0 : r_vcount + 11'd1;
      end else begin
        w_hcount_nxt = r_hcount + 11'd1;
      end
    end
  end

  // Register counters and decode the next-state position into zero-skew outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_blank       <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_blank       <= (w_hcount_nxt >= H_VIS) || (w_vcount_nxt >= V_VIS);
      r_hsync       <= in_window(w_hcount_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
      r_vsync       <= in_window(w_vcount_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign pix_en      = w_pix_en;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign blank       = r_blank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two instances share the clock: the
// full 640x480 mode with CLK_DIV=4, and a shrunken raster with CLK_DIV=1 so
// frame wrap and vsync are reachable in a short run. Expected observations
// are hand-computed against the clk-edge index and queued per instance; a
// monitor pops and compares them on the falling edge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        bl;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        pe;
  } obs_t;

  typedef struct {
    int    at;
    string name;
    obs_t  exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_m_n;
  logic rst_s_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  exp_t q_main[$];
  exp_t q_small[$];

  logic        m_pe, m_bl, m_hs, m_vs, m_ls, m_fs;
  logic [10:0] m_h, m_v;
  logic        s_pe, s_bl, s_hs, s_vs, s_ls, s_fs;
  logic [10:0] s_h, s_v;
  obs_t        obs_main, obs_small;

  assign obs_main  = {m_h, m_v, m_bl, m_hs, m_vs, m_ls, m_fs, m_pe};
  assign obs_small = {s_h, s_v, s_bl, s_hs, s_vs, s_ls, s_fs, s_pe};

  vga_timing_gen u_main (
    .clk         (clk),
    .reset_n     (rst_m_n),
    .pix_en      (m_pe),
    .hcount      (m_h),
    .vcount      (m_v),
    .blank       (m_bl),
    .hsync       (m_hs),
    .vsync       (m_vs),
    .line_start  (m_ls),
    .frame_start (m_fs)
  );

  // Shrunken raster: H 16+2+3+3=24 (hsync 18..20), V 8+2+2+2=14 (vsync 10..11).
  vga_timing_gen #(
    .CLK_DIV   (1),
    .H_VISIBLE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VISIBLE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_small (
    .clk         (clk),
    .reset_n     (rst_s_n),
    .pix_en      (s_pe),
    .hcount      (s_h),
    .vcount      (s_v),
    .blank       (s_bl),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got h=%0d v=%0d bl=%b hs=%b vs=%b ls=%b fs=%b pe=%b, expected h=%0d v=%0d bl=%b hs=%b vs=%b ls=%b fs=%b pe=%b",
               name, got.h, got.v, got.bl, got.hs, got.vs, got.ls, got.fs, got.pe,
               exp.h, exp.v, exp.bl, exp.hs, exp.vs, exp.ls, exp.fs, exp.pe);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // dut 0 = main, 1 = small; fields in order h v bl hs vs ls fs pe.
  task automatic push(input int dut, input int at, input string name,
                      input int h, input int v, input logic bl, input logic hs,
                      input logic vs, input logic ls, input logic fs, input logic pe);
    exp_t e;
    e.at     = at;
    e.name   = name;
    e.exp.h  = 11'(h);
    e.exp.v  = 11'(v);
    e.exp.bl = bl;
    e.exp.hs = hs;
    e.exp.vs = vs;
    e.exp.ls = ls;
    e.exp.fs = fs;
    e.exp.pe = pe;
    if (dut == 0) q_main.push_back(e);
    else          q_small.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation whose clk-edge index has arrived.
  initial begin
    forever begin
      @(negedge clk);
      while (q_main.size() > 0 && q_main[0].at <= cyc) begin
        exp_t e;
        e = q_main.pop_front();
        check({"main_", e.name}, obs_main, e.exp);
      end
      while (q_small.size() > 0 && q_small[0].at <= cyc) begin
        exp_t e;
        e = q_small.pop_front();
        check({"small_", e.name}, obs_small, e.exp);
      end
    end
  end

  // Stimulus. Reset is released after edge R=5; "e" below is the edge index
  // after release, so observation index = 5 + e.
  initial begin
    rst_m_n = 1'b0;
    rst_s_n = 1'b0;

    // Main (CLK_DIV=4): pixel p is visible after edges 4p+1 .. 4p+4; pix_en
    // is high after every edge that is a multiple of 4.
    push(0, 2,        "reset_hold",     0,   0, 0, 1, 1, 0, 0, 0);
    push(0, 5,        "reset_end",      0,   0, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 3,    "no_pix_yet",     0,   0, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 4,    "first_pix_en",   0,   0, 0, 1, 1, 0, 0, 1);
    push(0, 5 + 5,    "h1",             1,   0, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 8,    "pix_en_period",  1,   0, 0, 1, 1, 0, 0, 1);
    push(0, 5 + 9,    "h2",             2,   0, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 2560, "h639_visible",   639, 0, 0, 1, 1, 0, 0, 1);
    push(0, 5 + 2561, "h640_blank",     640, 0, 1, 1, 1, 0, 0, 0);
    push(0, 5 + 2621, "h655_no_sync",   655, 0, 1, 1, 1, 0, 0, 0);
    push(0, 5 + 2625, "h656_sync",      656, 0, 1, 0, 1, 0, 0, 0);
    push(0, 5 + 3008, "h751_sync",      751, 0, 1, 0, 1, 0, 0, 1);
    push(0, 5 + 3009, "h752_no_sync",   752, 0, 1, 1, 1, 0, 0, 0);
    push(0, 5 + 3200, "h799_v0",        799, 0, 1, 1, 1, 0, 0, 1);
    push(0, 5 + 3201, "line1_start",    0,   1, 0, 1, 1, 1, 0, 0);
    push(0, 5 + 3202, "line1_strobe_end", 0, 1, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 35200, "h799_v10",      799, 10, 1, 1, 1, 0, 0, 1);
    push(0, 5 + 35201, "line11_start",  0,   11, 0, 1, 1, 1, 0, 0);
    push(0, 5 + 35202, "line11_strobe_end", 0, 11, 0, 1, 1, 0, 0, 0);
    push(0, 5 + 36404, "h300_v11",      300, 11, 0, 1, 1, 0, 0, 1);
    push(0, 5 + 36405, "midframe_reset", 0,  0, 0, 1, 1, 0, 0, 0);

    // Small (CLK_DIV=1): pix_en high from the first edge after release,
    // pixel p (frame-linear) visible after edge p+1.
    push(1, 5,       "reset_end",       0,  0,  0, 1, 1, 0, 0, 0);
    push(1, 5 + 1,   "first_pix_en",    0,  0,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 2,   "h1",              1,  0,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 3,   "h2",              2,  0,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 16,  "h15_visible",     15, 0,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 17,  "h16_blank",       16, 0,  1, 1, 1, 0, 0, 1);
    push(1, 5 + 18,  "h17_no_sync",     17, 0,  1, 1, 1, 0, 0, 1);
    push(1, 5 + 19,  "h18_sync",        18, 0,  1, 0, 1, 0, 0, 1);
    push(1, 5 + 21,  "h20_sync",        20, 0,  1, 0, 1, 0, 0, 1);
    push(1, 5 + 22,  "h21_no_sync",     21, 0,  1, 1, 1, 0, 0, 1);
    push(1, 5 + 24,  "h23_v0",          23, 0,  1, 1, 1, 0, 0, 1);
    push(1, 5 + 25,  "line1_start",     0,  1,  0, 1, 1, 1, 0, 1);
    push(1, 5 + 26,  "line1_strobe_end", 1, 1,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 240, "v9_end",          23, 9,  1, 1, 1, 0, 0, 1);
    push(1, 5 + 241, "v10_vsync_on",    0,  10, 1, 1, 0, 1, 0, 1);
    push(1, 5 + 288, "v11_end_vsync",   23, 11, 1, 1, 0, 0, 0, 1);
    push(1, 5 + 289, "v12_vsync_off",   0,  12, 1, 1, 1, 1, 0, 1);
    push(1, 5 + 336, "frame_last_px",   23, 13, 1, 1, 1, 0, 0, 1);
    push(1, 5 + 337, "frame_wrap",      0,  0,  0, 1, 1, 1, 1, 1);
    push(1, 5 + 338, "frame_strobe_end", 1, 0,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 672, "frame2_last_px",  23, 13, 1, 1, 1, 0, 0, 1);
    push(1, 5 + 673, "frame2_wrap",     0,  0,  0, 1, 1, 1, 1, 1);
    push(1, 5 + 700, "h3_v1",           3,  1,  0, 1, 1, 0, 0, 1);
    push(1, 5 + 701, "midframe_reset",  0,  0,  0, 1, 1, 0, 0, 0);

    wait_cyc(5);
    rst_m_n = 1'b1;
    rst_s_n = 1'b1;

    // Small: one-clk reset while pix_en is high, mid-frame.
    wait_cyc(705);
    rst_s_n = 1'b0;
    wait_cyc(706);
    rst_s_n = 1'b1;
    push(1, 706 + 1, "post_reset_first", 0, 0, 0, 1, 1, 0, 0, 1);
    push(1, 706 + 2, "post_reset_h1",    1, 0, 0, 1, 1, 0, 0, 1);

    // Main: one-clk reset on an edge where pix_en is high at (300,11).
    wait_cyc(36409);
    rst_m_n = 1'b0;
    wait_cyc(36410);
    rst_m_n = 1'b1;
    push(0, 36410 + 3, "post_reset_no_pix", 0, 0, 0, 1, 1, 0, 0, 0);
    push(0, 36410 + 4, "post_reset_pix_en", 0, 0, 0, 1, 1, 0, 0, 1);
    push(0, 36410 + 5, "post_reset_h1",     1, 0, 0, 1, 1, 0, 0, 0);

    wait_cyc(36420);
    @(negedge clk);
    #1;
    check_int("main_scoreboard_drained",  q_main.size(),  0);
    check_int("small_scoreboard_drained", q_small.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
